// File: rtl/fifo_pkg.sv
// Shared FIFO package: FSM state encoding and a constant
// width helper used by the FIFO blocks.
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // ceil(log2(n)); usable in localparam expressions
  function automatic int clog2w(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// eligible_i/ptr_i -> first set bit at/after ptr (wrapping): onehot_o, idx_o, any_o.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] eligible_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  logic [IDXW-1:0] cand [NREQ];

  // cand[o] = (ptr + o) mod NREQ, valid for non-power-of-2 NREQ
  for (genvar o = 0; o < NREQ; o++) begin : g_cand
    logic [IDXW:0] sum;
    assign sum = {1'b0, ptr_i} + (IDXW+1)'(o);
    assign cand[o] = (sum >= (IDXW+1)'(NREQ)) ?
                     IDXW'(sum - (IDXW+1)'(NREQ)) :
                     IDXW'(sum);
  end

  // Scan from the farthest offset down so the nearest eligible wins
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = |eligible_i;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (eligible_i[cand[j]]) begin
        onehot_o          = '0;
        onehot_o[cand[j]] = 1'b1;
        idx_o             = cand[j];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of the FIFO write port.
// Ports: wclk/wrst, req/wdata_in/req_en in, wfull in; gnt/ack/winc/wdata/busy out.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] wdata_in,
  input  logic [NREQ-1:0]       req_en,
  input  logic                  wfull,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic                  busy
);

  localparam int IDXW = clog2w(NREQ);
  localparam int CNTW = clog2w(MAX_BURST + 1);
  localparam logic [CNTW-1:0] BEAT_LAST = CNTW'(MAX_BURST - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NREQ - 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [CNTW-1:0] beat_q, beat_d;
  logic [IDXW-1:0] ptr_q, ptr_d;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] pick_oh;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic            owner_ok;
  logic [DSIZE-1:0] slice [NREQ];

  assign eligible = req & req_en;
  assign owner_ok = req[idx_q] & req_en[idx_q];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slice[i] = wdata_in[i*DSIZE +: DSIZE];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .onehot_o   (pick_oh),
    .idx_o      (pick_idx),
    .any_o      (pick_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;
    winc    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BURST;
          gnt_d   = pick_oh;
          idx_d   = pick_idx;
          beat_d  = '0;
        end
      end
      BURST: begin
        // A word presented during reset is not written; it is retried
        winc = owner_ok & ~wfull & ~wrst;
        if (!owner_ok || (winc && beat_q == BEAT_LAST)) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          beat_d  = '0;
          ptr_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else if (winc) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt   = gnt_q;
  assign ack   = gnt_q & {NREQ{winc}};
  assign wdata = slice[idx_q];
  assign busy  = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester data scoreboard
// plus expected grant order / burst length queues.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int MAXB  = 4;

  logic                  wclk = 1'b0;
  logic                  wrst;
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] wdata_in;
  logic [NREQ-1:0]       req_en;
  logic                  wfull;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  busy;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DSIZE     (DSIZE),
    .MAX_BURST (MAXB)
  ) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .req      (req),
    .wdata_in (wdata_in),
    .req_en   (req_en),
    .wfull    (wfull),
    .gnt      (gnt),
    .ack      (ack),
    .winc     (winc),
    .wdata    (wdata),
    .busy     (busy)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_errors = 0;
  int n_tag [NREQ];
  logic [7:0] exp_q [NREQ][$];
  int exp_owner [$];
  int exp_len [$];
  logic [NREQ-1:0] s_gnt, s_ack;
  logic [NREQ-1:0] prev_gnt = '0;
  logic s_winc, s_busy;
  int beats = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tag_of(input int i, input int n);
    return 8'(8'hA0 + i * 16 + n);
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++)
      wdata_in[i*DSIZE +: DSIZE] = tag_of(i, n_tag[i]);
  endtask

  task automatic sample();
    int o;
    s_gnt  = gnt;
    s_ack  = ack;
    s_winc = winc;
    s_busy = busy;
    chk("invariant",
        {27'd0, winc & wfull,
         ack != (gnt & {NREQ{winc}}),
         winc & ~busy,
         busy != (gnt != '0),
         (prev_gnt != '0) && (gnt != '0) && (gnt != prev_gnt)},
        32'd0);
    if (gnt != '0 && prev_gnt == '0) begin
      beats = 0;
      if (exp_owner.size() > 0) begin
        o = exp_owner.pop_front();
        chk("gnt_order", 32'(gnt), 32'(1) << o);
      end
    end
    if (gnt == '0 && prev_gnt != '0 && exp_len.size() > 0)
      chk("burst_len", beats, exp_len.pop_front());
    if (winc) begin
      beats++;
      o = -1;
      for (int i = 0; i < NREQ; i++)
        if (ack[i]) o = i;
      if (o >= 0 && exp_q[o].size() > 0) begin
        chk("sb_data", 32'(wdata), 32'(exp_q[o].pop_front()));
        n_tag[o]++;
        exp_q[o].push_back(tag_of(o, n_tag[o]));
      end else begin
        chk("sb_unexpected", 32'(ack), 32'(gnt));
      end
    end
    prev_gnt = gnt;
  endtask

  task automatic cyc();
    @(negedge wclk);
    sample();
    @(posedge wclk);
    #1;
    drive_data();
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      n_tag[i] = 0;
      exp_q[i].push_back(tag_of(i, 0));
    end
    wrst   = 1'b1;
    req    = 4'b1111;
    req_en = 4'b1111;
    wfull  = 1'b0;
    drive_data();
    @(posedge wclk);
    #1;

    // Reset held two cycles with all requesting
    repeat (2) begin
      cyc();
      chk("rst_gnt", 32'(s_gnt), 32'd0);
      chk("rst_winc", 32'(s_winc), 32'd0);
      chk("rst_ack", 32'(s_ack), 32'd0);
      chk("rst_busy", 32'(s_busy), 32'd0);
    end
    wrst = 1'b0;

    // Fairness: 8 bursts of 4 in order 0,1,2,3
    for (int b = 0; b < 8; b++) begin
      exp_owner.push_back(b % NREQ);
      exp_len.push_back(MAXB);
    end
    repeat (40) cyc();
    req = 4'b0000;
    cyc();
    chk("fair_owner_left", exp_owner.size(), 32'd0);
    chk("fair_len_left", exp_len.size(), 32'd0);

    // Full stall mid-burst for owner 2
    req = 4'b0100;
    exp_owner.push_back(2);
    exp_len.push_back(MAXB);
    cyc();
    chk("stall_bubble", 32'(s_gnt), 32'd0);
    cyc();
    chk("stall_first", 32'(s_winc), 32'd1);
    wfull = 1'b1;
    repeat (5) begin
      cyc();
      chk("stall_gnt", 32'(s_gnt), 32'b0100);
      chk("stall_winc", 32'(s_winc), 32'd0);
    end
    wfull = 1'b0;
    repeat (3) begin
      cyc();
      chk("stall_resume", 32'(s_winc), 32'd1);
    end
    req = 4'b0000;
    cyc();
    chk("stall_idle", 32'(s_gnt), 32'd0);

    // Withdraw after 2 acks, requester 3 masked
    req = 4'b0010;
    exp_owner.push_back(1);
    exp_len.push_back(2);
    repeat (3) cyc();
    req    = 4'b1100;
    req_en = 4'b0111;
    for (int b = 0; b < 3; b++) begin
      exp_owner.push_back(2);
      exp_len.push_back(MAXB);
    end
    cyc();
    chk("wd_nowrite", 32'(s_winc), 32'd0);
    chk("wd_gnt", 32'(s_gnt), 32'b0010);
    cyc();
    chk("wd_idle", 32'(s_gnt), 32'd0);
    repeat (14) begin
      cyc();
      chk("mask3", 32'(s_gnt[3]), 32'd0);
    end
    req = 4'b0000;
    cyc();
    chk("wd_owner_left", exp_owner.size(), 32'd0);

    // Reset mid-burst at beat 2
    req    = 4'b0001;
    req_en = 4'b1111;
    exp_owner.push_back(0);
    exp_len.push_back(2);
    repeat (3) cyc();
    wrst = 1'b1;
    cyc();
    chk("rmid_winc", 32'(s_winc), 32'd0);
    wrst = 1'b0;
    req  = 4'b1001;
    exp_owner.push_back(0);
    exp_len.push_back(1);
    cyc();
    chk("rmid_gnt", 32'(s_gnt), 32'd0);
    chk("rmid_busy", 32'(s_busy), 32'd0);
    cyc();
    chk("rmid_ptr", 32'(s_gnt), 32'b0001);
    req = 4'b0000;
    repeat (2) cyc();

    chk("owner_q_empty", exp_owner.size(), 32'd0);
    chk("len_q_empty", exp_len.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
